// File: rtl/sprite_animator.sv
// Sprite renderer: maps the scan position to a sprite ROM address and emits palette indices
// after a fixed 3-cycle latency. A small FSM steps through the animation frames.
module sprite_animator #(
    parameter int SPR_W      = 100,
    parameter int SPR_H      = 120,
    parameter int NUM_FRAMES = 6,
    parameter int FRAME_HOLD = 4,
    parameter int IDX_BITS   = 3,
    parameter int ADDR_W     = 17,
    localparam int FN_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          draw_x,
    input  logic [9:0]          draw_y,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                flip,
    input  logic                loop_mode,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                blank,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS-1:0] pix_idx,
    output logic                pix_valid,
    output logic [FN_W-1:0]     frame_num,
    output logic                busy,
    output logic                done
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

    state_t              r_state, w_state_nx;
    logic [HOLD_W-1:0]   r_hold, w_hold_nx;
    logic [FN_W-1:0]     r_frame_num, w_frame_nx;
    logic                r_done, w_done_nx;
    logic                w_busy;

    logic [10:0]         w_x_end, w_y_end, w_dx, w_dy, w_col;
    logic                w_in_box;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_pix_valid;

    logic [ADDR_W-1:0]   r_rom_address;
    logic                r_inbox_d1, r_inbox_d2, r_blank_d1, r_blank_d2;
    logic [IDX_BITS-1:0] r_pix_idx;
    logic                r_pix_valid;

    // Box test and address generation, all in 11 bits so pos+size never wraps at 1023
    always_comb begin
        w_x_end  = {1'b0, pos_x} + 11'(SPR_W);
        w_y_end  = {1'b0, pos_y} + 11'(SPR_H);
        w_dx     = {1'b0, draw_x} - {1'b0, pos_x};
        w_dy     = {1'b0, draw_y} - {1'b0, pos_y};
        w_in_box = ({1'b0, draw_x} >= {1'b0, pos_x}) && ({1'b0, draw_x} < w_x_end) &&
                   ({1'b0, draw_y} >= {1'b0, pos_y}) && ({1'b0, draw_y} < w_y_end);
        if (flip) begin
            w_col = 11'(SPR_W - 1) - w_dx;
        end else begin
            w_col = w_dx;
        end
        if (w_in_box) begin
            w_addr = ADDR_W'(r_frame_num) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
        end else begin
            w_addr = {ADDR_W{1'b0}};
        end
        w_pix_valid = r_inbox_d2 && r_blank_d2 && (rom_q != {IDX_BITS{1'b0}});
    end

    // Pixel pipeline: address stage, ROM-latency alignment stage, output stage
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_address <= {ADDR_W{1'b0}};
            r_inbox_d1    <= 1'b0;
            r_inbox_d2    <= 1'b0;
            r_blank_d1    <= 1'b0;
            r_blank_d2    <= 1'b0;
            r_pix_idx     <= {IDX_BITS{1'b0}};
            r_pix_valid   <= 1'b0;
        end else begin
            r_rom_address <= w_addr;
            r_inbox_d1    <= w_in_box;
            r_inbox_d2    <= r_inbox_d1;
            r_blank_d1    <= blank;
            r_blank_d2    <= r_blank_d1;
            r_pix_valid   <= w_pix_valid;
            r_pix_idx     <= w_pix_valid ? rom_q : {IDX_BITS{1'b0}};
        end
    end

    // Animation state register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= {HOLD_W{1'b0}};
            r_frame_num <= {FN_W{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hold      <= w_hold_nx;
            r_frame_num <= w_frame_nx;
            r_done      <= w_done_nx;
        end
    end

    // Animation next-state logic; start always wins over a coincident tick
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_frame_nx = r_frame_num;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_nx  = {HOLD_W{1'b0}};
                w_frame_nx = {FN_W{1'b0}};
                if (start) begin
                    w_state_nx = ST_PLAY;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (start) begin
                    w_hold_nx  = {HOLD_W{1'b0}};
                    w_frame_nx = {FN_W{1'b0}};
                end else if (frame_tick) begin
                    if (r_hold == HOLD_W'(FRAME_HOLD - 1)) begin
                        w_hold_nx = {HOLD_W{1'b0}};
                        if (r_frame_num == FN_W'(NUM_FRAMES - 1)) begin
                            w_frame_nx = {FN_W{1'b0}};
                            if (loop_mode) begin
                                w_state_nx = ST_PLAY;
                            end else begin
                                w_state_nx = ST_IDLE;
                                w_done_nx  = 1'b1;
                            end
                        end else begin
                            w_frame_nx = r_frame_num + {{(FN_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_hold_nx = r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_hold_nx = r_hold;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_hold_nx  = {HOLD_W{1'b0}};
                w_frame_nx = {FN_W{1'b0}};
            end
        endcase
    end

    // Animation outputs decoded from the state register
    always_comb begin
        w_busy = (r_state == ST_PLAY);
    end

    assign rom_address = r_rom_address;
    assign pix_idx     = r_pix_idx;
    assign pix_valid   = r_pix_valid;
    assign frame_num   = r_frame_num;
    assign busy        = w_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator with a 4x2 sprite, 3 frames, 2 ticks per frame.
// ROM model: mem[a] = a[2:0], except mem[0] = 7 so out-of-box lookups return a non-transparent index.
module tb_sprite_animator;

    localparam int SPR_W = 4, SPR_H = 2, NUM_FRAMES = 3, FRAME_HOLD = 2, IDX_BITS = 3, ADDR_W = 5;

    logic                vga_clk = 1'b0;
    logic                reset_n;
    logic [9:0]          draw_x, draw_y, pos_x, pos_y;
    logic                flip, loop_mode, start, frame_tick, blank;
    logic [ADDR_W-1:0]   rom_address;
    logic [IDX_BITS-1:0] rom_q;
    logic [IDX_BITS-1:0] pix_idx;
    logic                pix_valid;
    logic [1:0]          frame_num;
    logic                busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
        .FRAME_HOLD(FRAME_HOLD), .IDX_BITS(IDX_BITS), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
        .flip(flip), .loop_mode(loop_mode), .start(start), .frame_tick(frame_tick),
        .blank(blank), .rom_address(rom_address), .rom_q(rom_q),
        .pix_idx(pix_idx), .pix_valid(pix_valid), .frame_num(frame_num),
        .busy(busy), .done(done)
    );

    always #5 vga_clk = ~vga_clk;

    // One-cycle-latency ROM model
    always @(posedge vga_clk) begin
        rom_q <= (rom_address == 5'd0) ? 3'd7 : rom_address[2:0];
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(2);
        n_tests++;
        if ({rom_address, pix_idx, pix_valid, frame_num, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d idx=%0d valid=%0b fn=%0d busy=%0b done=%0b, want all 0",
                     rom_address, pix_idx, pix_valid, frame_num, busy, done);
        end
        reset_n = 1'b1;
        step(1);
    endtask

    // Checks address one cycle after the draw sample and pixel outputs three cycles after
    task automatic check_pixel(input string name, input logic [9:0] dx, input logic [9:0] dy,
                               input logic fl, input logic bl, input logic [ADDR_W-1:0] exp_addr,
                               input logic exp_valid, input logic [IDX_BITS-1:0] exp_idx);
        draw_x = dx; draw_y = dy; flip = fl; blank = bl;
        step(1);
        n_tests++;
        if (rom_address !== exp_addr) begin
            n_fail++;
            $display("FAIL %s_addr: got %0d, want %0d", name, rom_address, exp_addr);
        end
        step(1);
        n_tests++;
        if (pix_valid !== 1'b0 && exp_valid === 1'b1 && name == "early") begin
            n_fail++;
            $display("FAIL %s_early: pixel appeared one cycle too soon", name);
        end
        step(1);
        n_tests++;
        if (pix_valid !== exp_valid || pix_idx !== exp_idx) begin
            n_fail++;
            $display("FAIL %s_pix: got valid=%0b idx=%0d, want valid=%0b idx=%0d",
                     name, pix_valid, pix_idx, exp_valid, exp_idx);
        end
    endtask

    task automatic test_address();
        pulse_start();
        tick_once();
        tick_once();
        n_tests++;
        if (frame_num !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_frame1: got fn=%0d busy=%0b, want fn=1 busy=1", frame_num, busy);
        end
        pos_x = 10'd10; pos_y = 10'd20;
        // frame1 base 8 + row1*4 + col2 = 14 -> rom 6; flipped col 1 -> 13 -> rom 5
        check_pixel("noflip",  10'd12, 10'd21, 1'b0, 1'b1, 5'd14, 1'b1, 3'd6);
        check_pixel("flip",    10'd12, 10'd21, 1'b1, 1'b1, 5'd13, 1'b1, 3'd5);
    endtask

    task automatic test_pixel();
        // Exact latency: pixel must still show the previous vector two cycles after a change
        draw_x = 10'd10; draw_y = 10'd20; flip = 1'b0; blank = 1'b1;
        step(2);
        n_tests++;
        if (pix_valid !== 1'b1 || pix_idx !== 3'd5) begin
            n_fail++;
            $display("FAIL latency_hold: got valid=%0b idx=%0d, want valid=1 idx=5", pix_valid, pix_idx);
        end
        step(1);
        n_tests++;
        if (pix_valid !== 1'b0 || pix_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL transparent: got valid=%0b idx=%0d, want valid=0 idx=0", pix_valid, pix_idx);
        end
        check_pixel("blanked",  10'd12, 10'd21, 1'b1, 1'b0, 5'd13, 1'b0, 3'd0);
        check_pixel("lastcol",  10'd13, 10'd21, 1'b0, 1'b1, 5'd15, 1'b1, 3'd7);
    endtask

    task automatic test_out_of_box();
        check_pixel("right_edge", 10'd14, 10'd20, 1'b0, 1'b1, 5'd0, 1'b0, 3'd0);
        check_pixel("left_edge",  10'd9,  10'd20, 1'b0, 1'b1, 5'd0, 1'b0, 3'd0);
        check_pixel("below",      10'd11, 10'd22, 1'b0, 1'b1, 5'd0, 1'b0, 3'd0);
        pos_x = 10'd1020;
        check_pixel("nowrap",     10'd2,    10'd20, 1'b0, 1'b1, 5'd0,  1'b0, 3'd0);
        check_pixel("far_right",  10'd1022, 10'd20, 1'b0, 1'b1, 5'd10, 1'b1, 3'd2);
        pos_x = 10'd10;
    endtask

    task automatic test_anim_once();
        logic [1:0] exp_fn [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        loop_mode = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (frame_num !== exp_fn[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL once_seq[%0d]: got fn=%0d busy=%0b, want fn=%0d busy=1",
                         i, frame_num, busy, exp_fn[i]);
            end
            tick_once();
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || frame_num !== 2'd0) begin
            n_fail++;
            $display("FAIL once_end: got done=%0b busy=%0b fn=%0d, want done=1 busy=0 fn=0",
                     done, busy, frame_num);
        end
        step(1);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done=%0b, want 0", done);
        end
        tick_once();
        tick_once();
        n_tests++;
        if (busy !== 1'b0 || frame_num !== 2'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick: got busy=%0b fn=%0d done=%0b, want 0 0 0", busy, frame_num, done);
        end
    endtask

    task automatic test_anim_loop();
        loop_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick_once();
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL loop_nodone[%0d]: got done=%0b, want 0", i, done);
            end
        end
        n_tests++;
        if (frame_num !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_wrap: got fn=%0d busy=%0b, want fn=0 busy=1", frame_num, busy);
        end
    endtask

    task automatic test_start_tick();
        for (int i = 0; i < 4; i++) tick_once();
        n_tests++;
        if (frame_num !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_restart: got fn=%0d, want 2", frame_num);
        end
        start = 1'b1; frame_tick = 1'b1;
        step(1);
        start = 1'b0; frame_tick = 1'b0;
        n_tests++;
        if (frame_num !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got fn=%0d busy=%0b, want fn=0 busy=1", frame_num, busy);
        end
        tick_once();
        n_tests++;
        if (frame_num !== 2'd0) begin
            n_fail++;
            $display("FAIL restart_hold0: got fn=%0d after one tick, want 0", frame_num);
        end
        tick_once();
        n_tests++;
        if (frame_num !== 2'd1) begin
            n_fail++;
            $display("FAIL restart_hold1: got fn=%0d after two ticks, want 1", frame_num);
        end
    endtask

    task automatic test_reset_mid_play();
        check_pixel("preload", 10'd12, 10'd21, 1'b0, 1'b1, 5'd14, 1'b1, 3'd6);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rom_address, pix_idx, pix_valid, frame_num, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d idx=%0d valid=%0b fn=%0d busy=%0b done=%0b, want all 0",
                     rom_address, pix_idx, pix_valid, frame_num, busy, done);
        end
        step(1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_once();
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || frame_num !== 2'd0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got busy=%0b done=%0b fn=%0d, want 0 0 0",
                         i, busy, done, frame_num);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        draw_x = 10'd0; draw_y = 10'd0; pos_x = 10'd0; pos_y = 10'd0;
        flip = 1'b0; loop_mode = 1'b0; start = 1'b0; frame_tick = 1'b0; blank = 1'b0;
        test_reset();
        test_address();
        test_pixel();
        test_out_of_box();
        test_anim_once();
        test_anim_loop();
        test_start_tick();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 SHALL provide parameter SPR_W, default 100, sprite width in pixels.
REQ-002 SHALL provide parameter SPR_H, default 120, sprite height in pixels.
REQ-003 SHALL provide parameter NUM_FRAMES, default 6, animation frames stored back-to-back in ROM.
REQ-004 SHALL provide parameter FRAME_HOLD, default 4, frame_tick pulses per animation frame (>=1).
REQ-005 SHALL provide parameter IDX_BITS, default 3, palette index width.
REQ-006 SHALL provide parameter ADDR_W, default 17, ROM address width (>= clog2(SPR_W*SPR_H*NUM_FRAMES)).
REQ-007 SHALL have ports: vga_clk  in  1  pixel clock, all logic on posedge.
REQ-008 reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 draw_x, draw_y  in  10 each  current scan pixel.
REQ-010 pos_x, pos_y  in  10 each  sprite top-left corner.
REQ-011 flip  in  1  horizontal mirror; loop_mode  in  1  1=repeat animation.
REQ-012 start  in  1  one-cycle animation trigger; frame_tick  in  1  one-cycle pulse per video frame.
REQ-013 blank  in  1  1=active video.
REQ-014 rom_address  out  ADDR_W  to ROM; rom_q  in  IDX_BITS  ROM data, one-cycle read latency.
REQ-015 pix_idx  out  IDX_BITS; pix_valid  out  1; frame_num  out  clog2(NUM_FRAMES); busy  out  1; done  out  1.

Function
REQ-016 Stage 1 (edge k+1) SHALL register rom_address from draw_x/draw_y sampled at edge k; ROM returns rom_q at edge k+2; stage 3 (edge k+3) SHALL register pix_idx/pix_valid: fixed 3-cycle latency from draw coordinates to pixel outputs.
REQ-017 in_box SHALL be draw_x>=pos_x && draw_x<pos_x+SPR_W && draw_y>=pos_y && draw_y<pos_y+SPR_H, computed in 11 bits (no wrap at 1023).
REQ-018 col SHALL be draw_x-pos_x, or SPR_W-1-(draw_x-pos_x) when flip=1; row SHALL be draw_y-pos_y.
REQ-019 rom_address SHALL be frame_num*SPR_W*SPR_H + row*SPR_W + col when in_box, else 0.
REQ-020 in_box and blank SHALL be delayed 2 cycles to align with rom_q.
REQ-021 pix_valid SHALL be 1 only when delayed in_box=1, delayed blank=1 and rom_q!=0 (index 0 is transparent); pix_idx SHALL be rom_q when pix_valid=1, else 0.
REQ-022 Animation FSM states: IDLE, PLAY.
REQ-023 IDLE: frame_num=0, busy=0; start=1 -> PLAY with frame_num=0, hold counter=0.
REQ-024 PLAY: busy=1; each frame_tick increments hold counter; when counter==FRAME_HOLD-1 at a tick, counter->0 and frame_num advances by 1.
REQ-025 Advance from frame NUM_FRAMES-1: loop_mode=1 -> frame_num=0, stay PLAY; loop_mode=0 -> IDLE, frame_num=0, done=1 for exactly one cycle.
REQ-026 start in PLAY SHALL restart at frame 0, counter 0; start and frame_tick in the same cycle: start wins, tick ignored.
REQ-027 frame_tick in IDLE SHALL be ignored.
REQ-028 flip, pos_x, pos_y and frame_num changes SHALL take effect on the next sampled pixel; no internal latching beyond the pipeline.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, hold counter 0, frame_num 0, rom_address 0, pipeline in_box/blank 0, pix_idx 0, pix_valid 0, busy 0, done 0.
REQ-030 Reset mid-PLAY SHALL abandon the animation with no done pulse; after release, operation resumes only on a new start.

Verification (SPR_W=4, SPR_H=2, NUM_FRAMES=3, FRAME_HOLD=2, IDX_BITS=3)
REQ-031 frame 1, pos(10,20), draw(12,21), flip=0 -> rom_address=14 one cycle later; flip=1 -> 13.
REQ-032 ROM returns 5 with blank=1, in box -> pix_idx=5, pix_valid=1 exactly 3 cycles after draw sample; rom_q=0 -> pix_valid=0, pix_idx=0.
REQ-033 draw(14,20) or draw(9,20) with pos(10,20) -> rom_address=0, pix_valid=0; pos_x=1020, draw_x=2 -> out of box (no wrap).
REQ-034 start, loop_mode=0, 6 ticks -> frame_num 0,0,1,1,2,2 sequence, then IDLE with done pulsed one cycle; loop_mode=1 -> frame_num returns to 0, busy stays 1.
REQ-035 start coincident with tick while frame_num=2 -> frame_num=0, counter 0; reset_n low mid-PLAY -> all outputs 0 immediately, no done.
